// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between uart_rx and Peripheral, first-word-fall-through read port.
// Define UART_RX_FIFO_IRQ_EN to add the registered rx_irq pulse output.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic [7:0]        rd_data,
  output logic              rx_status,
  output logic [ADDR_W:0]   count,
`ifdef UART_RX_FIFO_IRQ_EN
  output logic              overflow,
  output logic              rx_irq
`else
  output logic              overflow
`endif
);

  localparam logic [ADDR_W:0] FullCnt = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              pop, push, drop, full;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte.
  always_comb begin
    full       = (count_q == FullCnt);
    pop        = rd_en && (count_q != '0);
    push       = i_Rx_DV && (!full || pop);
    drop       = i_Rx_DV && full && !pop;
    wp_d       = push ? wp_q + 1'b1 : wp_q;
    rp_d       = pop  ? rp_q + 1'b1 : rp_q;
    count_d    = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (ovf_clr)
      overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push)
      mem_q[wp_q] <= i_Rx_Byte;
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic rx_irq_q;

  always_ff @(posedge clk) begin
    if (!reset)
      rx_irq_q <= 1'b0;
    else
      rx_irq_q <= ((count_q == '0) && (count_d != '0)) || (!overflow_q && overflow_d);
  end

  assign rx_irq = rx_irq_q;
`endif

  assign rd_data   = (count_q != '0) ? mem_q[rp_q] : 8'h00;
  assign rx_status = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              reset;
  logic              i_Rx_DV;
  logic [7:0]        i_Rx_Byte;
  logic              rd_en;
  logic              ovf_clr;
  logic [7:0]        rd_data;
  logic              rx_status;
  logic [ADDR_W:0]   count;
  logic              overflow;
`ifdef UART_RX_FIFO_IRQ_EN
  logic              rx_irq;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] modelQ[$];
  logic       modelOvf = 1'b0;
  logic       modelIrq = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_Rx_DV   (i_Rx_DV),
    .i_Rx_Byte (i_Rx_Byte),
    .rd_en     (rd_en),
    .ovf_clr   (ovf_clr),
    .rd_data   (rd_data),
    .rx_status (rx_status),
    .count     (count),
`ifdef UART_RX_FIFO_IRQ_EN
    .overflow  (overflow),
    .rx_irq    (rx_irq)
`else
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle, advances the reference model, then compares every output.
  task automatic applyStimulus(input logic rstN, input logic dv, input logic [7:0] b,
                               input logic rd, input logic clr);
    int  sizeBefore;
    logic ovfBefore, popOk, isFull, doPush, doDrop;
    @(negedge clk);
    reset     = rstN;
    i_Rx_DV   = dv;
    i_Rx_Byte = b;
    rd_en     = rd;
    ovf_clr   = clr;
    @(posedge clk);
    sizeBefore = modelQ.size();
    ovfBefore  = modelOvf;
    if (!rstN) begin
      modelQ.delete();
      modelOvf = 1'b0;
      modelIrq = 1'b0;
    end else begin
      popOk  = rd && (sizeBefore > 0);
      isFull = (sizeBefore == DEPTH);
      doPush = dv && (!isFull || popOk);
      doDrop = dv && isFull && !popOk;
      if (popOk)  void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(b);
      if (doDrop) modelOvf = 1'b1;
      else if (clr) modelOvf = 1'b0;
      modelIrq = ((sizeBefore == 0) && (modelQ.size() != 0)) || (!ovfBefore && modelOvf);
    end
    #1;
    checkOutput("count",     32'(count),     32'(modelQ.size()));
    checkOutput("rx_status", 32'(rx_status), 32'(modelQ.size() != 0));
    checkOutput("rd_data",   32'(rd_data),   (modelQ.size() != 0) ? 32'(modelQ[0]) : 32'h0);
    checkOutput("overflow",  32'(overflow),  32'(modelOvf));
`ifdef UART_RX_FIFO_IRQ_EN
    checkOutput("rx_irq",    32'(rx_irq),    32'(modelIrq));
`endif
  endtask

  initial begin
    reset = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;

    // Reset held two cycles while bytes are strobed: they must be lost.
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_data",  32'(rd_data), 32'h0);

    // Ordering.
    applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    checkOutput("order_head", 32'(rd_data), 32'hA1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("order_empty", 32'(rx_status), 32'd0);

    // Overflow: nine pushes into eight slots, drain, then clear the flag.
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("ovf_count", 32'(count), 32'd8);
    checkOutput("ovf_flag",  32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h18, 1'b1, 1'b0);
    checkOutput("full_pp_data", 32'(rd_data), 32'h11);
    checkOutput("full_pp_ovf",  32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Empty FIFO with simultaneous push and pop, then pointer wrap.
    applyStimulus(1'b1, 1'b1, 8'h7E, 1'b1, 1'b0);
    checkOutput("empty_pp_count", 32'(count), 32'd1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Drop coincident with ovf_clr: set must win.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    checkOutput("set_wins", 32'(overflow), 32'd1);

    // Random traffic, including occasional resets mid-stream.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) >= 2),
                    ($urandom_range(0, 99) < 55),
                    8'($urandom),
                    ($urandom_range(0, 99) < 45),
                    ($urandom_range(0, 99) < 6));
    end

    @(negedge clk);
    i_Rx_DV = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; reset = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
